// File: rtl/regfile_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_arbiter
// Shares one 2**ADDR_W x DATA_W register file between two masters (m0, m1).
// After reset an optional init sweep writes INIT_VAL to every location; then
// single read/write transactions are served one at a time with round-robin
// arbitration. The file's read pipeline (RD_LAT edges) is hidden behind a
// req/ack handshake per master.
//
// Ports
//   clk_i            clock, all logic on posedge
//   reset_i          synchronous active-high reset
//   mX_req_i         request, held with a stable command until mX_ack_o
//   mX_we_i          1 = write, 0 = read
//   mX_addr_i        address
//   mX_wdata_i       write data
//   mX_ack_o         one-cycle completion pulse
//   mX_rdata_o       read data, valid in ack cycle, held until next read of mX
//   rf_wr_en_o       register file write enable
//   rf_rd_en_o       register file read enable
//   rf_addr_o        register file address
//   rf_data_in_o     register file write data
//   rf_data_out_i    register file read data
//   busy_o           high in every state except IDLE
//   init_done_o      high from the end of the init sweep until the next reset
// -----------------------------------------------------------------------------
module regfile_arbiter #(
    parameter int                ADDR_W   = 4,
    parameter int                DATA_W   = 8,
    parameter int                RD_LAT   = 2,
    parameter int                INIT_EN  = 1,
    parameter logic [DATA_W-1:0] INIT_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_ack_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_ack_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              rf_wr_en_o,
    output logic              rf_rd_en_o,
    output logic [ADDR_W-1:0] rf_addr_o,
    output logic [DATA_W-1:0] rf_data_in_o,
    input  logic [DATA_W-1:0] rf_data_out_i,
    output logic              busy_o,
    output logic              init_done_o
);

    localparam int                CNT_W     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0]  WAIT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W:0]   INIT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam state_t RESET_STATE = (INIT_EN != 0) ? ST_INIT : ST_IDLE;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     init_cnt_q, init_cnt_d;
    logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic                grant_q, grant_d;
    logic                last_grant_q, last_grant_d;
    logic                we_q, we_d;
    logic                rf_wr_en_q, rf_wr_en_d;
    logic                rf_rd_en_q, rf_rd_en_d;
    logic [ADDR_W-1:0]   rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0]   rf_data_in_q, rf_data_in_d;
    logic                m0_ack_q, m0_ack_d;
    logic                m1_ack_q, m1_ack_d;
    logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;
    logic                busy_q, busy_d;
    logic                init_done_q, init_done_d;
    logic                sel_s;

    // Next-state and next-output logic; every output is computed one cycle
    // ahead so that it appears registered in the state it belongs to.
    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        rf_wr_en_d   = 1'b0;
        rf_rd_en_d   = 1'b0;
        rf_addr_d    = rf_addr_q;
        rf_data_in_d = rf_data_in_q;
        m0_ack_d     = 1'b0;
        m1_ack_d     = 1'b0;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;
        init_done_d  = init_done_q;
        sel_s        = 1'b0;

        case (state_q)
            ST_INIT: begin
                // MSB of the sweep counter marks that every address was written
                if (init_cnt_q[ADDR_W] == 1'b0) begin
                    rf_wr_en_d   = 1'b1;
                    rf_addr_d    = init_cnt_q[ADDR_W-1:0];
                    rf_data_in_d = INIT_VAL;
                    init_cnt_d   = init_cnt_q + INIT_ONE;
                end else begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                end
            end
            ST_IDLE: begin
                init_done_d = 1'b1;
                if (m0_req_i || m1_req_i) begin
                    // Contention goes to the master that was not granted last
                    if (m0_req_i && m1_req_i) begin
                        sel_s = ~last_grant_q;
                    end else begin
                        sel_s = m1_req_i;
                    end
                    grant_d      = sel_s;
                    last_grant_d = sel_s;
                    we_d         = sel_s ? m1_we_i : m0_we_i;
                    rf_addr_d    = sel_s ? m1_addr_i : m0_addr_i;
                    rf_data_in_d = sel_s ? m1_wdata_i : m0_wdata_i;
                    if (we_d) begin
                        rf_wr_en_d = 1'b1;
                    end else begin
                        rf_rd_en_d = 1'b1;
                    end
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (we_q) begin
                    state_d  = ST_DONE;
                    m0_ack_d = ~grant_q;
                    m1_ack_d = grant_q;
                end else begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = {CNT_W{1'b0}};
                end
            end
            ST_WAIT: begin
                // Read data is valid by the last wait edge; capture it there
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d  = ST_DONE;
                    m0_ack_d = ~grant_q;
                    m1_ack_d = grant_q;
                    if (grant_q) begin
                        m1_rdata_d = rf_data_out_i;
                    end else begin
                        m0_rdata_d = rf_data_out_i;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= RESET_STATE;
            init_cnt_q   <= {(ADDR_W+1){1'b0}};
            wait_cnt_q   <= {CNT_W{1'b0}};
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            rf_wr_en_q   <= 1'b0;
            rf_rd_en_q   <= 1'b0;
            rf_addr_q    <= {ADDR_W{1'b0}};
            rf_data_in_q <= {DATA_W{1'b0}};
            m0_ack_q     <= 1'b0;
            m1_ack_q     <= 1'b0;
            m0_rdata_q   <= {DATA_W{1'b0}};
            m1_rdata_q   <= {DATA_W{1'b0}};
            busy_q       <= 1'b0;
            init_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            rf_wr_en_q   <= rf_wr_en_d;
            rf_rd_en_q   <= rf_rd_en_d;
            rf_addr_q    <= rf_addr_d;
            rf_data_in_q <= rf_data_in_d;
            m0_ack_q     <= m0_ack_d;
            m1_ack_q     <= m1_ack_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
            busy_q       <= busy_d;
            init_done_q  <= init_done_d;
        end
    end

    assign m0_ack_o     = m0_ack_q;
    assign m1_ack_o     = m1_ack_q;
    assign m0_rdata_o   = m0_rdata_q;
    assign m1_rdata_o   = m1_rdata_q;
    assign rf_wr_en_o   = rf_wr_en_q;
    assign rf_rd_en_o   = rf_rd_en_q;
    assign rf_addr_o    = rf_addr_q;
    assign rf_data_in_o = rf_data_in_q;
    assign busy_o       = busy_q;
    assign init_done_o  = init_done_q;

endmodule
